// File: rtl/bus_source_arbiter_if.sv
// Bus-source arbitration interface: per-source requests in, one-hot select and owner status out.
// The arbiter connects through the slave modport; the requesting side uses master.
interface bus_source_arbiter_if #(
  parameter int N_SRC = 24
);
  logic [N_SRC-1:0] req;
  logic [31:0]      gnt;
  logic [4:0]       gnt_idx;
  logic             busy;
  logic             timeout;

  modport master (output req, input gnt, gnt_idx, busy, timeout);
  modport slave  (input req, output gnt, gnt_idx, busy, timeout);
endinterface

// File: rtl/bus_source_arbiter.sv
// Round-robin owner arbiter for the shared CPU bus with a one-cycle dead gap between owners.
// Optional forced release after MAX_HOLD owned cycles when BUS_ARB_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | no owner, arbitrate every cycle
// OWN   | gnt held for the owner until its req drops (or hold limit)
// GAP   | one dead cycle, gnt = 0, arbitrate at its end
module bus_source_arbiter #(
  parameter int N_SRC    = 24,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 clr_n,
  bus_source_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [4:0] NO_SRC = 5'd31;

  if (N_SRC < 1 || N_SRC > 31) begin : g_bad_nsrc
    $error("bus_source_arbiter: N_SRC out of range");
  end
  if (MAX_HOLD < 1) begin : g_bad_hold
    $error("bus_source_arbiter: MAX_HOLD must be at least 1");
  end

  logic [1:0]  state;
  logic [4:0]  ptr;
  logic [31:0] req32;
  logic        win_found;
  logic [4:0]  win_idx;
  logic [4:0]  next_ptr;
  logic        own_drop;
  logic        tmo_hit;

  assign req32    = 32'(bus.req);
  assign own_drop = !req32[bus.gnt_idx];
  assign next_ptr = (bus.gnt_idx >= 5'(N_SRC - 1)) ? 5'd0 : bus.gnt_idx + 5'd1;

  // Search upward from ptr, wrapping at N_SRC; first requester wins.
  always_comb begin
    logic [5:0] j;
    win_found = 1'b0;
    win_idx   = 5'd0;
    j         = 6'd0;
    for (int i = 0; i < N_SRC; i++) begin
      j = {1'b0, ptr} + 6'(i);
      if (j >= 6'(N_SRC)) j = j - 6'(N_SRC);
      if (!win_found && req32[j[4:0]]) begin
        win_found = 1'b1;
        win_idx   = j[4:0];
      end
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_TC = CW'(MAX_HOLD - 1);

  logic [CW-1:0] hold_cnt;

  // Zero outside OWN, so it is already clear on the edge that enters OWN.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)
      hold_cnt <= '0;
    else if (state != S_OWN)
      hold_cnt <= '0;
    else
      hold_cnt <= hold_cnt + 1'b1;
  end

  assign tmo_hit = (state == S_OWN) && !own_drop && (hold_cnt == HOLD_TC);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state       <= S_IDLE;
      ptr         <= 5'd0;
      bus.gnt     <= 32'd0;
      bus.gnt_idx <= NO_SRC;
      bus.busy    <= 1'b0;
      bus.timeout <= 1'b0;
    end else begin
      bus.timeout <= 1'b0;
      case (state)
        S_OWN: begin
          if (own_drop || tmo_hit) begin
            state       <= S_GAP;
            ptr         <= next_ptr;
            bus.gnt     <= 32'd0;
            bus.gnt_idx <= NO_SRC;
            bus.busy    <= 1'b0;
            bus.timeout <= tmo_hit;
          end
        end
        default: begin
          if (win_found) begin
            state       <= S_OWN;
            bus.gnt     <= 32'd1 << win_idx;
            bus.gnt_idx <= win_idx;
            bus.busy    <= 1'b1;
          end else begin
            state       <= S_IDLE;
            bus.gnt     <= 32'd0;
            bus.gnt_idx <= NO_SRC;
            bus.busy    <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Directed bench for bus_source_arbiter: vector table plus reset and hold-limit sequences.
// Covers the BUS_ARB_TIMEOUT_EN build when that macro is defined, the plain build otherwise.
module tb_bus_source_arbiter;

  logic clk;
  logic clr_n;
  int   n_chk;
  int   n_pass;

  bus_source_arbiter_if #(.N_SRC(24)) bus ();

  bus_source_arbiter #(.N_SRC(24), .MAX_HOLD(8)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] req;
    logic [31:0] gnt;
    logic [4:0]  idx;
    logic        busy;
  } vec_t;

  vec_t vecs [25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check_out(input string name, input logic [31:0] g, input logic [4:0] idx,
                           input logic busy, input logic tmo);
    check({name, ".gnt"},     bus.gnt,            g);
    check({name, ".gnt_idx"}, 32'(bus.gnt_idx),   32'(idx));
    check({name, ".busy"},    32'(bus.busy),      32'(busy));
    check({name, ".timeout"}, 32'(bus.timeout),   32'(tmo));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #2 clr_n = 1'b0;
    #1 clr_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;

    vecs[0]  = '{24'h000000, 32'h00000000, 5'd31, 1'b0};
    vecs[1]  = '{24'h000004, 32'h00000004, 5'd2,  1'b1};
    vecs[2]  = '{24'h000004, 32'h00000004, 5'd2,  1'b1};
    vecs[3]  = '{24'h000000, 32'h00000000, 5'd31, 1'b0};
    vecs[4]  = '{24'h000000, 32'h00000000, 5'd31, 1'b0};
    vecs[5]  = '{24'h000408, 32'h00000008, 5'd3,  1'b1};
    vecs[6]  = '{24'h000400, 32'h00000000, 5'd31, 1'b0};
    vecs[7]  = '{24'h000400, 32'h00000400, 5'd10, 1'b1};
    vecs[8]  = '{24'h000000, 32'h00000000, 5'd31, 1'b0};
    vecs[9]  = '{24'h000000, 32'h00000000, 5'd31, 1'b0};
    vecs[10] = '{24'h080000, 32'h00080000, 5'd19, 1'b1};
    vecs[11] = '{24'h000000, 32'h00000000, 5'd31, 1'b0};
    vecs[12] = '{24'h400002, 32'h00400000, 5'd22, 1'b1};
    vecs[13] = '{24'h000002, 32'h00000000, 5'd31, 1'b0};
    vecs[14] = '{24'h000002, 32'h00000002, 5'd1,  1'b1};
    vecs[15] = '{24'h000002, 32'h00000002, 5'd1,  1'b1};
    vecs[16] = '{24'h000000, 32'h00000000, 5'd31, 1'b0};
    vecs[17] = '{24'h800001, 32'h00800000, 5'd23, 1'b1};
    vecs[18] = '{24'h000001, 32'h00000000, 5'd31, 1'b0};
    vecs[19] = '{24'h000001, 32'h00000001, 5'd0,  1'b1};
    vecs[20] = '{24'h000003, 32'h00000001, 5'd0,  1'b1};
    vecs[21] = '{24'h000002, 32'h00000000, 5'd31, 1'b0};
    vecs[22] = '{24'h000002, 32'h00000002, 5'd1,  1'b1};
    vecs[23] = '{24'h000000, 32'h00000000, 5'd31, 1'b0};
    vecs[24] = '{24'h000000, 32'h00000000, 5'd31, 1'b0};

    // Reset values must appear without any clock edge.
    bus.req = '0;
    clr_n   = 1'b1;
    #2 clr_n = 1'b0;
    #2;
    check_out("reset", 32'h0, 5'd31, 1'b0, 1'b0);
    #3 clr_n = 1'b1;

    for (int v = 0; v < 25; v++) begin
      bus.req = vecs[v].req;
      tick();
      check_out($sformatf("vec%0d", v), vecs[v].gnt, vecs[v].idx, vecs[v].busy, 1'b0);
    end

    // Mid-grant reset; ptr is 2 here, so regranting 0 over 7 proves ptr returned to 0.
    bus.req = 24'h000080;
    tick();
    check_out("own7", 32'h00000080, 5'd7, 1'b1, 1'b0);
    #2 clr_n = 1'b0;
    #1;
    check_out("midreset", 32'h0, 5'd31, 1'b0, 1'b0);
    bus.req = 24'h000081;
    #1 clr_n = 1'b1;
    tick();
    check_out("after_reset", 32'h00000001, 5'd0, 1'b1, 1'b0);
    bus.req = '0;
    tick();
    tick();
    check_out("idle_again", 32'h0, 5'd31, 1'b0, 1'b0);

    pulse_reset();
    bus.req = 24'h000060;
`ifdef BUS_ARB_TIMEOUT_EN
    begin
      int held;
      held = 0;
      for (int c = 0; c < 20; c++) begin
        tick();
        if (bus.gnt === 32'h00000020) held++;
        else break;
      end
      check("hold_cycles", 32'(held), 32'd8);
      check_out("tmo_gap", 32'h0, 5'd31, 1'b0, 1'b1);
      tick();
      check_out("tmo_next", 32'h00000040, 5'd6, 1'b1, 1'b0);
      bus.req = 24'h000040;
      for (int c = 0; c < 7; c++) begin
        tick();
        check_out($sformatf("own6_%0d", c), 32'h00000040, 5'd6, 1'b1, 1'b0);
      end
      bus.req = '0;
      tick();
      check_out("drop_at_limit", 32'h0, 5'd31, 1'b0, 1'b0);
    end
`else
    for (int c = 0; c < 100; c++) begin
      tick();
      check($sformatf("notmo_gnt%0d", c), bus.gnt, 32'h00000020);
      check($sformatf("notmo_tmo%0d", c), 32'(bus.timeout), 32'd0);
    end
    bus.req = '0;
    tick();
    check_out("notmo_release", 32'h0, 5'd31, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
